pwm_multi_ch: RTL and testbench

PWM_MULTI_CH -- requirements
Module: pwm_multi_ch

---
 rtl/pwm_pkg.sv | 17 +
 rtl/pwm_debounce.sv | 35 +++
 rtl/pwm_multi_ch.sv | 188 ++++++++++++++++++
 tb/tb_pwm_multi_ch.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and types for the multi-channel PWM block.
package pwm_pkg;

  // Guard bits on duty arithmetic so saturation is exact without wrap-around.
  localparam int DUTY_GUARD_W = 1;
  localparam int DUTY_MIN     = 1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  function automatic int ch_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/pwm_debounce.sv
// Button conditioner: 2-FF synchroniser, tick-enabled two-stage sampler and
// a single-cycle press pulse on each debounced rising edge.
module pwm_debounce (
  input  logic clk,
  input  logic rst_n,
  input  logic i_tick,
  input  logic i_btn,
  output logic o_press
);

  logic r_sync1;
  logic r_sync2;
  logic r_s1;
  logic r_s2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      if (i_tick) begin
        r_s1 <= r_sync2;
        r_s2 <= r_s1;
      end
    end
  end

  // s2 catches up with s1 on the same tick, so the pulse lasts one cycle.
  assign o_press = r_s1 & ~r_s2 & i_tick;

endmodule

// File: rtl/pwm_multi_ch.sv
// N_CH-channel PWM with debounced inc/dec buttons and wrap-synchronous duty
// update. Macro PWM_CENTER_ALIGN_EN selects up/down (center-aligned) counting.
module pwm_multi_ch
  import pwm_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int CNT_W     = 8,
  parameter int PERIOD    = 10,
  parameter int DUTY_INIT = 5,
  parameter int DUTY_STEP = 1,
  parameter int DEB_DIV   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inc_i,
  input  logic                    dec_i,
  input  logic [ch_w(N_CH)-1:0]   ch_sel_i,
  output logic [N_CH-1:0]         pwm_o,
  output logic                    period_end_o,
  output logic [CNT_W-1:0]        duty_o
);

  localparam int CH_W  = ch_w(N_CH);
  localparam int DW    = CNT_W + DUTY_GUARD_W;
  localparam int PRE_W = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;

  localparam logic [CNT_W-1:0] TOP     = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] INIT    = CNT_W'(DUTY_INIT);
  localparam logic [CNT_W-1:0] MIN_D   = CNT_W'(DUTY_MIN);
  localparam logic [DW-1:0]    STEP_X  = DW'(DUTY_STEP);
  localparam logic [DW-1:0]    TOP_X   = DW'(PERIOD - 1);
  localparam logic [DW-1:0]    MIN_X   = DW'(DUTY_MIN);
  localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(DEB_DIV - 1);

  logic [PRE_W-1:0] r_presc;
  logic             w_tick;
  logic             w_inc_p;
  logic             w_dec_p;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_wrap;
  logic             r_period_end;
  logic [N_CH-1:0]  r_pwm;

  logic [CNT_W-1:0] r_pend [N_CH];
  logic [CNT_W-1:0] r_act  [N_CH];

  logic             w_sel_ok;
  logic [CNT_W-1:0] w_pend_sel;
  logic [DW-1:0]    w_sum_x;
  logic [DW-1:0]    w_diff_x;
  logic [CNT_W-1:0] w_inc_duty;
  logic [CNT_W-1:0] w_dec_duty;
  logic             w_do_inc;
  logic             w_do_dec;

  // Debounce sample tick
  assign w_tick = (r_presc == PRE_TOP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
    end
  end

  pwm_debounce u_deb_inc (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_tick  (w_tick),
    .i_btn   (inc_i),
    .o_press (w_inc_p)
  );

  pwm_debounce u_deb_dec (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_tick  (w_tick),
    .i_btn   (dec_i),
    .o_press (w_dec_p)
  );

  // Period counter
`ifdef PWM_CENTER_ALIGN_EN
  dir_e r_dir;
  dir_e w_dir_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt + 1'b1;
    w_dir_nxt = r_dir;
    w_wrap    = 1'b0;
    unique case (r_dir)
      DIR_UP: begin
        if (r_cnt == TOP) begin
          w_dir_nxt = DIR_DOWN;
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      DIR_DOWN: begin
        // Bottom of the down slope is the wrap point; restart the up slope at 1.
        if (r_cnt == '0) begin
          w_wrap    = 1'b1;
          w_dir_nxt = DIR_UP;
          w_cnt_nxt = CNT_W'(1);
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_dir_nxt = DIR_UP;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dir <= DIR_UP;
    end else begin
      r_dir <= w_dir_nxt;
    end
  end
`else
  always_comb begin
    w_wrap    = (r_cnt == TOP);
    w_cnt_nxt = w_wrap ? '0 : r_cnt + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_period_end <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_period_end <= w_wrap;
    end
  end

  // Duty arithmetic on the selected channel
  assign w_sel_ok   = (int'(ch_sel_i) < N_CH);
  assign w_pend_sel = w_sel_ok ? r_pend[ch_sel_i] : '0;
  assign w_sum_x    = DW'(w_pend_sel) + STEP_X;
  assign w_diff_x   = DW'(w_pend_sel) - STEP_X;
  assign w_inc_duty = (w_sum_x > TOP_X) ? TOP : w_sum_x[CNT_W-1:0];
  // Guard bit set means the subtraction borrowed.
  assign w_dec_duty = (w_diff_x[CNT_W] || (w_diff_x < MIN_X)) ? MIN_D : w_diff_x[CNT_W-1:0];
  assign w_do_inc   = w_inc_p & ~w_dec_p;
  assign w_do_dec   = w_dec_p & ~w_inc_p;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        r_pend[i] <= INIT;
        r_act[i]  <= INIT;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (w_wrap) begin
          r_act[i] <= r_pend[i];
        end
        if (w_sel_ok && (CH_W'(i) == ch_sel_i)) begin
          if (w_do_inc) begin
            r_pend[i] <= w_inc_duty;
          end else if (w_do_dec) begin
            r_pend[i] <= w_dec_duty;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pwm <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        r_pwm[i] <= (r_cnt < r_act[i]);
      end
    end
  end

  assign pwm_o        = r_pwm;
  assign period_end_o = r_period_end;
  assign duty_o       = w_sel_ok ? r_act[ch_sel_i] : '0;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Scoreboarded bench for pwm_multi_ch: directed scenarios plus random presses
// against a per-channel duty model; a monitor measures whole PWM periods.
module tb_pwm_multi_ch;

  localparam int NCH   = 4;
  localparam int CW    = 8;
  localparam int P     = 10;
  localparam int INIT  = 5;
  localparam int STEP  = 1;
`ifdef PWM_CENTER_ALIGN_EN
  localparam int PLEN  = 2 * (P - 1);
  localparam int FIRST = 2 * (P - 1) + 1;
`else
  localparam int PLEN  = P;
  localparam int FIRST = P;
`endif

  typedef logic [NCH-1:0][CW-1:0] dv_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           inc_i = 1'b0;
  logic           dec_i = 1'b0;
  logic [1:0]     ch_sel_i = '0;
  logic [NCH-1:0] pwm_o;
  logic           period_end_o;
  logic [CW-1:0]  duty_o;

  int  n_pass  = 0;
  int  n_total = 0;
  int  model [NCH];
  dv_t exp_q [$];
  bit  meas = 1'b0;

  pwm_multi_ch #(
    .N_CH(NCH), .CNT_W(CW), .PERIOD(P), .DUTY_INIT(INIT), .DUTY_STEP(STEP), .DEB_DIV(2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inc_i        (inc_i),
    .dec_i        (dec_i),
    .ch_sel_i     (ch_sel_i),
    .pwm_o        (pwm_o),
    .period_end_o (period_end_o),
    .duty_o       (duty_o)
  );

  always #5 clk = ~clk;

  function automatic int exp_hi(input int d);
`ifdef PWM_CENTER_ALIGN_EN
    return 2 * d - 1;
`else
    return d;
`endif
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  function automatic dv_t model_vec();
    dv_t v;
    for (int i = 0; i < NCH; i++) v[i] = CW'(model[i]);
    return v;
  endfunction

  // Monitor: measures each period following a pushed expectation.
  initial begin : monitor
    int  len;
    int  hi [NCH];
    dv_t cur;
    len = 0;
    foreach (hi[i]) hi[i] = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        meas = 1'b0;
        continue;
      end
      if (period_end_o) begin
        if (meas) begin
          cur = exp_q.pop_front();
          check("period_len", len, PLEN);
          for (int i = 0; i < NCH; i++)
            check($sformatf("pwm_high_ch%0d", i), hi[i], exp_hi(int'(cur[i])));
          meas = 1'b0;
        end
        if (exp_q.size() > 0) begin
          meas = 1'b1;
          len  = 0;
          foreach (hi[i]) hi[i] = 0;
        end
      end
      if (meas) begin
        len++;
        for (int i = 0; i < NCH; i++) hi[i] += int'(pwm_o[i]);
      end
    end
  end

  task automatic wait_pe(input int max_cyc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_end_o && n < max_cyc);
    if (!period_end_o) begin
      n_total++;
      $display("FAIL period_end_timeout: no pulse within %0d cycles", max_cyc);
    end
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || meas) && k < 6 * PLEN) begin
      @(negedge clk);
      k++;
    end
    if (k >= 6 * PLEN) begin
      n_total++;
      $display("FAIL scoreboard_drain: %0d entries left", exp_q.size());
    end
  endtask

  task automatic settle_push();
    int n;
    wait_pe(3 * PLEN, n);
    wait_pe(3 * PLEN, n);
    exp_q.push_back(model_vec());
    wait_drain();
  endtask

  task automatic model_press(input bit inc, input bit dec, input int ch);
    if (ch >= NCH) return;
    if (inc && !dec) model[ch] = (model[ch] + STEP > P - 1) ? P - 1 : model[ch] + STEP;
    else if (dec && !inc) model[ch] = (model[ch] - STEP < 1) ? 1 : model[ch] - STEP;
  endtask

  task automatic press(input bit inc, input bit dec, input int ch);
    ch_sel_i = 2'(ch);
    inc_i = inc;
    dec_i = dec;
    repeat (8) @(negedge clk);
    inc_i = 1'b0;
    dec_i = 1'b0;
    repeat (8) @(negedge clk);
    model_press(inc, dec, ch);
  endtask

  task automatic check_duties(input string tag);
    for (int c = 0; c < NCH; c++) begin
      ch_sel_i = 2'(c);
      #1;
      check($sformatf("%s_duty_ch%0d", tag, c), int'(duty_o), model[c]);
    end
  endtask

  task automatic model_reset();
    foreach (model[i]) model[i] = INIT;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    model_reset();

    // Reset state and first period
    repeat (3) @(negedge clk);
    check("rst_pwm", int'(pwm_o), 0);
    check("rst_period_end", int'(period_end_o), 0);
    check_duties("rst");
    rst_n = 1'b1;
    wait_pe(3 * PLEN, n);
    check("first_period_end", n, FIRST);
    exp_q.push_back(model_vec());
    wait_drain();

    // Increment to the upper limit on ch2
    repeat (6) press(1'b1, 1'b0, 2);
    settle_push();
    check_duties("inc_sat");

    // Decrement to the lower limit on ch0
    repeat (6) press(1'b0, 1'b1, 0);
    settle_push();
    check_duties("dec_sat");

    // Simultaneous buttons cancel
    press(1'b1, 1'b1, 1);
    press(1'b1, 1'b1, 3);
    settle_push();
    check_duties("both");

    // Mid-period press only becomes active at the next wrap
    wait_pe(3 * PLEN, n);
    ch_sel_i = 2'd3;
    inc_i = 1'b1;
    repeat (7) @(negedge clk);
    check("midperiod_duty_before_wrap", int'(duty_o), model[3]);
    wait_pe(3 * PLEN, n);
    model_press(1'b1, 1'b0, 3);
    check("midperiod_duty_after_wrap", int'(duty_o), model[3]);
    inc_i = 1'b0;
    repeat (8) @(negedge clk);
    settle_push();

    // Reset at cnt=6 with ch1 at 8
    repeat (3) press(1'b1, 1'b0, 1);
    settle_push();
    check_duties("pre_rst");
    wait_pe(3 * PLEN, n);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    model_reset();
    check("midrst_pwm", int'(pwm_o), 0);
    check("midrst_period_end", int'(period_end_o), 0);
    ch_sel_i = 2'd1;
    #1;
    check("midrst_duty_ch1", int'(duty_o), INIT);
    rst_n = 1'b1;
    wait_pe(3 * PLEN, n);
    check("midrst_first_period_end", n, FIRST);
    exp_q.push_back(model_vec());
    wait_drain();

    // Button held through reset release yields exactly one press
    rst_n = 1'b0;
    ch_sel_i = 2'd3;
    inc_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (14) @(negedge clk);
    inc_i = 1'b0;
    repeat (8) @(negedge clk);
    model_reset();
    model_press(1'b1, 1'b0, 3);
    settle_push();
    check_duties("held_rst");

    // Random presses against the model
    for (int it = 0; it < 25; it++) begin
      int ch;
      int op;
      int cnt;
      ch  = int'($urandom_range(0, NCH - 1));
      cnt = int'($urandom_range(1, 3));
      for (int k = 0; k < cnt; k++) begin
        op = int'($urandom_range(0, 2));
        press(op != 1, op != 0, ch);
      end
      settle_push();
    end
    check_duties("rand_final");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
